// File: rtl/cap_pkg.sv
// Shared defaults and state type for the CAM tag resolver.
// Build option: TAG_RESOLVER_COUNT_EN adds a remaining-match counter.
package cap_pkg;

    localparam int CAM_N_WORDS = 100;
    localparam int CAM_IDX_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } res_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit encoder; bit 0 has the highest priority.
// Used by tag_resolver (TAG_RESOLVER_COUNT_EN does not affect it).
module priority_encoder #(
    parameter int WIDTH = 100,
    parameter int IDX_W = 7
) (
    input  logic [WIDTH-1:0] vector,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Walk downwards so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vector[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_resolver.sv
// Resolves a CAM tag vector into one responder index per handshake.
// Build option: TAG_RESOLVER_COUNT_EN adds the match_count output.
module tag_resolver
    import cap_pkg::*;
#(
    parameter int N_WORDS = CAM_N_WORDS,
    parameter int IDX_W   = CAM_IDX_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               abort,
    input  logic [N_WORDS-1:0] tags_in,
    input  logic               idx_ready,
    output logic               busy,
    output logic               any_tag,
    output logic               idx_valid,
    output logic [IDX_W-1:0]   idx,
    output logic [N_WORDS-1:0] clear_mask,
`ifdef TAG_RESOLVER_COUNT_EN
    output logic [IDX_W:0]     match_count,
`endif
    output logic               done
);

    res_state_e         state_q;
    res_state_e         state_d;
    logic [N_WORDS-1:0] snap_q;
    logic [N_WORDS-1:0] snap_d;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_found;
    logic [N_WORDS-1:0] onehot;
    logic [N_WORDS-1:0] snap_left;
    logic               in_scan;
    logic               hshake;

    priority_encoder #(
        .WIDTH (N_WORDS),
        .IDX_W (IDX_W)
    ) u_penc (
        .vector (snap_q),
        .index  (enc_idx),
        .found  (enc_found)
    );

    assign in_scan   = (state_q == ST_SCAN);
    assign onehot    = {{(N_WORDS-1){1'b0}}, 1'b1} << enc_idx;
    assign snap_left = snap_q & ~onehot;
    assign hshake    = in_scan && enc_found && idx_ready && !abort;

    assign busy       = (state_q != ST_IDLE);
    assign any_tag    = |snap_q;
    assign idx_valid  = in_scan;
    assign idx        = (in_scan && enc_found) ? enc_idx : '0;
    assign clear_mask = hshake ? onehot : '0;
    assign done       = (state_q == ST_DONE) && !abort;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = tags_in;
                    state_d = (|tags_in) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (hshake) begin
                    snap_d = snap_left;
                    if (!(|snap_left)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over start and over any pending handshake.
        if (abort) begin
            state_d = ST_IDLE;
            snap_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
        end
    end

`ifdef TAG_RESOLVER_COUNT_EN
    logic [IDX_W:0] cnt_q;
    logic [IDX_W:0] cnt_d;
    logic [IDX_W:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            pop = pop + (IDX_W+1)'(tags_in[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (state_q == ST_IDLE && start) begin
            cnt_d = pop;
        end else if (hshake) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: doc/tag_resolver.md
TAG_RESOLVER -- requirements
Module: tag_resolver

Interface
REQ-001 Parameter N_WORDS, default 100, number of tagged CAM words.
REQ-002 Parameter IDX_W, default 7, index width; SHALL satisfy 2**IDX_W >= N_WORDS.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begin resolving the current tag vector.
REQ-006 abort  input  1  terminate resolution; return to IDLE.
REQ-007 tags_in  input  N_WORDS  tag vector from the tag register; bit i set = word i responded.
REQ-008 idx_ready  input  1  consumer accepts idx this cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 any_tag  output  1  high when the internal snapshot has at least one bit set.
REQ-011 idx_valid  output  1  idx holds a valid responder index.
REQ-012 idx  output  IDX_W  index of the lowest-numbered set snapshot bit.
REQ-013 clear_mask  output  N_WORDS  one-hot pulse clearing the accepted word's tag.
REQ-014 done  output  1  one-cycle pulse at the end of a resolution.

Function
REQ-015 States SHALL be IDLE, SCAN and DONE; the encoding is internal.
REQ-016 IDLE with start=1: capture tags_in into snapshot; go to SCAN if tags_in is nonzero, else to DONE.
REQ-017 start SHALL be ignored in SCAN and DONE.
REQ-018 SCAN: idx_valid=1 combinationally; idx = lowest set snapshot bit (select-first priority, bit 0 highest).
REQ-019 SCAN with idx_ready=1 (handshake):
- that snapshot bit clears next cycle;
- clear_mask = one-hot(idx) in the same cycle;
- if no other bit remains set, go to DONE.
REQ-020 SCAN with idx_ready=0: idx and idx_valid held stable; snapshot unchanged; clear_mask=0.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-022 Throughput: one index per cycle while idx_ready is held high.
REQ-023 Latency: first idx_valid appears one cycle after start.
REQ-024 abort=1 in any state: next state IDLE; snapshot cleared; no done pulse; clear_mask=0 that cycle; abort overrides start and the handshake.
REQ-025 Outside SCAN: idx_valid=0, idx=0, clear_mask=0.
REQ-026 Snapshot bits at positions >= N_WORDS SHALL not exist; idx never exceeds N_WORDS-1.

Reset
REQ-027 RST_N low SHALL force state IDLE and snapshot to 0.
REQ-028 While RST_N is low: busy=0, any_tag=0, idx_valid=0, idx=0, clear_mask=0, done=0.
REQ-029 Reset asserted mid-SCAN SHALL abandon the resolution with no done pulse.

Configuration
REQ-030 Macro TAG_RESOLVER_COUNT_EN, when defined, SHALL add output match_count, width IDX_W+1, with this behaviour:
- loaded with popcount(tags_in) at start;
- decremented on each handshake;
- reset to 0 by reset and by abort.
REQ-031 Without TAG_RESOLVER_COUNT_EN, the match_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package cap_pkg SHALL hold the N_WORDS and IDX_W defaults and the resolver state enum type.
REQ-033 Lowest-set-bit selection SHALL be a sub-module named priority_encoder, with ports vector in, index out and found out.

Verification
REQ-034 Reset: RST_N=0 mid-SCAN -> all outputs 0 immediately, state IDLE; no done pulse after release.
REQ-035 Empty search: start with tags_in=0 -> done on cycle+1, idx_valid never asserted.
REQ-036 Multiple responders, ready held high: start with bits {3,17,99} set -> idx 3, 17, 99 on three consecutive cycles; clear_mask one-hot each cycle; done on the next cycle.
REQ-037 Backpressure: bits {5,6} set, idx_ready low for 4 cycles -> idx=5 held stable, clear_mask=0; after ready, 5 then 6.
REQ-038 Abort: abort during SCAN with bits {0,50} set -> IDLE next cycle; any_tag=0; no done pulse; a start in the same cycle is ignored.
REQ-039 With TAG_RESOLVER_COUNT_EN: start with 3 bits set -> match_count reads 3, 2, 1, 0 across the handshakes.
